// File: rtl/frame_color_scan_ctrl.sv
// Scan sequencer for the frame buffer processing port: walks every pixel, classifies
// it as red/green/blue/none, accumulates per-colour counts and reports the dominant colour.
module frame_color_scan_ctrl #(
  parameter int AW      = 15,
  parameter int DW      = 12,
  parameter int NPIX    = 19200,
  parameter int THR     = 4,
  parameter int MIN_CNT = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cam_busy,
  output logic [AW-1:0] proc_addr,
  input  logic [DW-1:0] proc_data,
  output logic          busy,
  output logic          done,
  output logic [1:0]    color,
  output logic [14:0]   red_cnt,
  output logic [14:0]   green_cnt,
  output logic [14:0]   blue_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
  localparam logic [AW-1:0] BLACK_ADDR = AW'(NPIX);
  localparam logic [4:0]    THR5       = 5'(THR);
  localparam logic [14:0]   MIN15      = 15'(MIN_CNT);

  state_t      state, state_nxt;
  logic        sample, last_sample, launch;
  logic [DW-1:0] pix;
  logic        pix_valid;
  logic [14:0] acc_r, acc_g, acc_b;
  logic [4:0]  r5, g5, b5;
  logic        is_red, is_green, is_blue;
  logic [1:0]  dom_color;
  logic [14:0] dom_cnt;

  assign sample      = (state == SCAN) && !cam_busy;
  assign last_sample = sample && (proc_addr == LAST_ADDR);
  assign launch      = (state == IDLE) && start && !cam_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = SCAN;
      SCAN:    if (last_sample) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESULT;
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-extend to 5 bits so channel + THR cannot wrap.
  always_comb begin
    r5       = {1'b0, pix[11:8]};
    g5       = {1'b0, pix[7:4]};
    b5       = {1'b0, pix[3:0]};
    is_red   = (r5 >= g5 + THR5) && (r5 >= b5 + THR5);
    is_green = (g5 >= r5 + THR5) && (g5 >= b5 + THR5);
    is_blue  = (b5 >= r5 + THR5) && (b5 >= g5 + THR5);
  end

  // Largest count wins; ties resolve red > green > blue.
  always_comb begin
    dom_color = 2'b01;
    dom_cnt   = acc_r;
    if (!(acc_r >= acc_g && acc_r >= acc_b)) begin
      if (acc_g >= acc_b) begin
        dom_color = 2'b10;
        dom_cnt   = acc_g;
      end else begin
        dom_color = 2'b11;
        dom_cnt   = acc_b;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proc_addr <= BLACK_ADDR;
      busy      <= 1'b0;
      done      <= 1'b0;
      color     <= 2'b00;
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
      acc_r     <= '0;
      acc_g     <= '0;
      acc_b     <= '0;
      pix       <= '0;
      pix_valid <= 1'b0;
    end else begin
      done      <= 1'b0;
      pix_valid <= sample;
      if (sample) pix <= proc_data;

      if (pix_valid) begin
        if (is_red)   acc_r <= acc_r + 15'd1;
        if (is_green) acc_g <= acc_g + 15'd1;
        if (is_blue)  acc_b <= acc_b + 15'd1;
      end

      unique case (state)
        IDLE: begin
          proc_addr <= BLACK_ADDR;
          if (launch) begin
            proc_addr <= '0;
            acc_r     <= '0;
            acc_g     <= '0;
            acc_b     <= '0;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (sample) proc_addr <= last_sample ? BLACK_ADDR : proc_addr + 1'b1;
        end
        DRAIN: ;
        RESULT: begin
          red_cnt   <= acc_r;
          green_cnt <= acc_g;
          blue_cnt  <= acc_b;
          color     <= (dom_cnt >= MIN15) ? dom_color : 2'b00;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_color_scan_ctrl.sv
// Directed bench for frame_color_scan_ctrl: a behavioural frame buffer feeds the
// processing port, and each scenario checks counts, colour, latency and handshakes.
module tb_frame_color_scan_ctrl;

  localparam int AW      = 15;
  localparam int DW      = 12;
  localparam int NPIX    = 8192;  // smaller frame; every scenario address and count still fits
  localparam int THR     = 4;
  localparam int MIN_CNT = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          cam_busy = 1'b0;
  logic [AW-1:0] proc_addr;
  logic [DW-1:0] proc_data;
  logic          busy, done;
  logic [1:0]    color;
  logic [14:0]   red_cnt, green_cnt, blue_cnt;

  logic [DW-1:0] fb [0:NPIX];
  int unsigned   cyc = 0;
  int unsigned   e0 = 0;
  int            done_seen = 0;
  int            vectors = 0;
  int            miscompares = 0;

  frame_color_scan_ctrl #(
    .AW(AW), .DW(DW), .NPIX(NPIX), .THR(THR), .MIN_CNT(MIN_CNT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cam_busy(cam_busy),
    .proc_addr(proc_addr), .proc_data(proc_data),
    .busy(busy), .done(done), .color(color),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_seen <= done_seen + 1;

  always_comb proc_data = (int'(proc_addr) <= NPIX) ? fb[proc_addr] : '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [DW-1:0] px);
    for (int i = 0; i < NPIX; i++) fb[i] = px;
    fb[NPIX] = '0;
  endtask

  task automatic put(input int base, input int n, input logic [DW-1:0] px);
    for (int i = base; i < base + n; i++) fb[i] = px;
  endtask

  task automatic begin_scan(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_addr0"}, proc_addr, 0);
  endtask

  task automatic wait_addr(input int target);
    for (int i = 0; i < NPIX + 16; i++) begin
      if (int'(proc_addr) == target) break;
      @(posedge clk);
      #1;
    end
    check("wait_addr", proc_addr, target);
  endtask

  task automatic finish_scan(input string tag, input int exp_lat,
                             input int r, input int g, input int b, input int col);
    int lat;
    lat = -1;
    for (int i = 0; i < NPIX + 400; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = int'(cyc - e0);
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_red"}, red_cnt, r);
    check({tag, "_green"}, green_cnt, g);
    check({tag, "_blue"}, blue_cnt, b);
    check({tag, "_color"}, color, col);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_addr_idle"}, proc_addr, NPIX);
    check({tag, "_red_hold"}, red_cnt, r);
  endtask

  initial begin
    fill('0);

    // Reset values while rst is held low
    #12;
    check("rst_addr", proc_addr, NPIX);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_color", color, 0);
    check("rst_red", red_cnt, 0);
    check("rst_green", green_cnt, 0);
    check("rst_blue", blue_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full red frame
    fill(12'hF00);
    begin_scan("allred");
    finish_scan("allred", NPIX + 2, NPIX, 0, 0, 1);

    // Green majority with some blue on black
    fill(12'h000);
    put(100, 600, 12'h0F0);
    put(3000, 400, 12'h00F);
    begin_scan("green");
    finish_scan("green", NPIX + 2, 0, 600, 400, 2);

    // Red below MIN_CNT on grey; 12'h420 has R-G below THR and counts nowhere
    fill(12'h888);
    put(0, 500, 12'hF00);
    fb[700] = 12'h420;
    fb[701] = 12'h420;
    begin_scan("minred");
    finish_scan("minred", NPIX + 2, 500, 0, 0, 0);

    // Red/blue tie resolves to red
    fill(12'h000);
    put(0, 1000, 12'hF00);
    put(1000, 1000, 12'h00F);
    begin_scan("tie");
    finish_scan("tie", NPIX + 2, 1000, 0, 1000, 1);

    // Start while the camera is writing: scan must wait
    fill(12'hF00);
    @(negedge clk);
    cam_busy = 1'b1;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("cam_hold_busy", busy, 0);
    check("cam_hold_addr", proc_addr, NPIX);
    @(negedge clk);
    cam_busy = 1'b0;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    check("cam_start_busy", busy, 1);
    check("cam_start_addr", proc_addr, 0);

    // Camera pause of 100 cycles at address 5000
    wait_addr(5000);
    cam_busy = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1;
      check("cam_freeze_addr", proc_addr, 5000);
    end
    cam_busy = 1'b0;
    finish_scan("campause", NPIX + 2 + 100, NPIX, 0, 0, 1);

    // Reset mid-scan discards everything
    begin_scan("partial");
    wait_addr(8000);
    rst = 1'b0;
    #1;
    check("midrst_addr", proc_addr, NPIX);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_color", color, 0);
    check("midrst_red", red_cnt, 0);
    check("midrst_green", green_cnt, 0);
    check("midrst_blue", blue_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Fresh scan with stray start pulses while busy: one done only
    @(negedge clk);
    done_seen = 0;
    begin_scan("restart");
    repeat (3) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    finish_scan("restart", NPIX + 2, NPIX, 0, 0, 1);
    repeat (30) @(posedge clk);
    #1;
    check("restart_single_done", done_seen, 1);
    check("restart_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
